// File: rtl/crc_stream_pkg.sv
// Shared types and helpers for the CRC stream datapath.
// Holds the packet FSM state encoding and a one-hot test.
package crc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam int MAX_PORTS = 16;

  // True iff exactly one bit is set.
  // Selects narrower than MAX_PORTS are zero-extended by the caller.
  function automatic logic is_onehot(
    input logic [MAX_PORTS-1:0] v
  );
    return (v != '0) &&
      ((v & (v - MAX_PORTS'(1))) == '0);
  endfunction

endpackage

// File: rtl/lib_skid_buffer.sv
// Generic 2-entry skid buffer with registered in_ready.
// Ports: in_data/in_valid/in_ready, out_data/out_valid/out_ready, clk, rst.
module lib_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic [1:0]   cnt;
  logic [1:0]   cnt_n;
  logic         push;
  logic         pop;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = e0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign cnt_n     = cnt + {1'b0, push}
                   - {1'b0, pop};

  // in_ready is registered, so it is low whenever
  // cnt is 2; a push can never land on a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      in_ready <= 1'b1;
      e0       <= '0;
      e1       <= '0;
    end else begin
      cnt      <= cnt_n;
      in_ready <= (cnt_n != 2'd2);
      if (push && (cnt == 2'd0 ||
                   (cnt == 2'd1 && pop)))
        e0 <= in_data;
      else if (pop && cnt == 2'd2)
        e0 <= e1;
      if (push && cnt == 2'd1 && !pop)
        e1 <= in_data;
    end
  end

endmodule

// File: rtl/crc_lane_demux.sv
// Packet-level one-hot demux feeding the CRC lanes.
// Ports: s_* input stream + sel_i, m_* lane outputs, err_o drop pulse.
module crc_lane_demux
  import crc_stream_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  input  logic [PORTS-1:0] sel_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  output logic [PORTS-1:0] m_valid_o,
  input  logic [PORTS-1:0] m_ready_i,
  output logic             err_o
);

  localparam int PW = WIDTH + 1 + PORTS;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [PORTS-1:0] lane;
  } beat_t;

  state_e           state;
  logic [PORTS-1:0] lane_q;
  logic             accept;
  logic             legal;
  logic             enq;
  logic             head_valid;
  logic             head_ready;
  beat_t            in_beat;
  beat_t            head;

  assign accept = s_valid_i & s_ready_o;
  assign legal  = is_onehot(MAX_PORTS'(sel_i));

  // Only first beats with a legal select, or
  // beats of a routed packet, reach the buffer.
  assign enq = s_valid_i &
    ((state == IDLE && legal) ||
     (state == ROUTE));

  assign in_beat.data = s_data_i;
  assign in_beat.last = s_last_i;
  assign in_beat.lane = (state == IDLE)
                      ? sel_i : lane_q;

  // Only the tagged lane's ready can pop the head.
  assign head_ready = |(head.lane & m_ready_i);

  lib_skid_buffer #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_beat),
    .in_valid  (enq),
    .in_ready  (s_ready_o),
    .out_data  (head),
    .out_valid (head_valid),
    .out_ready (head_ready)
  );

  assign m_data_o  = head.data;
  assign m_last_o  = head.last;
  assign m_valid_o = head_valid ? head.lane : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lane_q <= '0;
      err_o  <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (legal) lane_q <= sel_i;
            else       err_o  <= 1'b1;
            if (!s_last_i)
              state <= legal ? ROUTE : DROP;
          end
          ROUTE, DROP: begin
            if (s_last_i) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
